// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one memory port between the cpu and an external
// requester. The winning request is latched in IDLE, it drives the memory for
// MEM_LAT cycles, read data is captured, and a one-cycle ack goes to the owner.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned CPU_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        rstb,
    // cpu port
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    // external port
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic        ext_ack,
    output logic [31:0] ext_rdata,
    // memory side
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_ena,
    input  logic [31:0] mem_rd_data,
    // status
    output logic        busy,
    output logic        owner
);

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    // Latched request payload of the current owner.
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_req_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t          state,       state_n;
    logic [CNT_W-1:0] cnt,        cnt_n;
    mem_req_t        req_q,       req_n;
    logic            last_owner,  last_owner_n;
    logic            owner_n;
    logic            busy_n;
    logic            cpu_ack_n,   ext_ack_n;
    logic [DW-1:0]   cpu_rdata_n, ext_rdata_n;
    logic [AW-1:0]   mem_addr_n;
    logic [DW-1:0]   mem_wr_data_n;
    logic            mem_wr_ena_n;
    logic            grant_ext_c;
    mem_req_t        cpu_pkt_c,   ext_pkt_c;

    // Pack incoming requests and decide which port wins an IDLE sample.
    always_comb begin
        cpu_pkt_c.we    = cpu_we;
        cpu_pkt_c.addr  = cpu_addr;
        cpu_pkt_c.wdata = cpu_wdata;
        ext_pkt_c.we    = ext_we;
        ext_pkt_c.addr  = ext_addr;
        ext_pkt_c.wdata = ext_wdata;
        grant_ext_c     = 1'b0;
        if (ext_req && !cpu_req) begin
            grant_ext_c = 1'b1;
        end else if (ext_req && cpu_req && (CPU_PRIORITY == 0)) begin
            // round-robin: the port that did not own the last transaction wins
            grant_ext_c = !last_owner;
        end
    end

    // Next-state and next-output logic; memory outputs are registered and
    // therefore computed for the state being entered.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        req_n         = req_q;
        last_owner_n  = last_owner;
        owner_n       = owner;
        busy_n        = 1'b0;
        cpu_ack_n     = 1'b0;
        ext_ack_n     = 1'b0;
        cpu_rdata_n   = cpu_rdata;
        ext_rdata_n   = ext_rdata;
        mem_addr_n    = '0;
        mem_wr_data_n = '0;
        mem_wr_ena_n  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cpu_req || ext_req) begin
                    req_n         = grant_ext_c ? ext_pkt_c : cpu_pkt_c;
                    owner_n       = grant_ext_c;
                    last_owner_n  = grant_ext_c;
                    cnt_n         = '0;
                    state_n       = ST_ACCESS;
                    busy_n        = 1'b1;
                    mem_addr_n    = req_n.addr;
                    mem_wr_data_n = req_n.wdata;
                    mem_wr_ena_n  = req_n.we;
                end
            end
            ST_ACCESS: begin
                cnt_n  = cnt + CNT_W'(1);
                busy_n = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_n = ST_ACK;
                    if (!req_q.we) begin
                        if (owner) ext_rdata_n = mem_rd_data;
                        else       cpu_rdata_n = mem_rd_data;
                    end
                    cpu_ack_n = !owner;
                    ext_ack_n = owner;
                end else begin
                    mem_addr_n    = req_q.addr;
                    mem_wr_data_n = req_q.wdata;
                end
            end
            ST_ACK: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction immediately.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            req_q       <= '0;
            last_owner  <= 1'b1;
            owner       <= 1'b0;
            busy        <= 1'b0;
            cpu_ack     <= 1'b0;
            ext_ack     <= 1'b0;
            cpu_rdata   <= '0;
            ext_rdata   <= '0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_wr_ena  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            req_q       <= req_n;
            last_owner  <= last_owner_n;
            owner       <= owner_n;
            busy        <= busy_n;
            cpu_ack     <= cpu_ack_n;
            ext_ack     <= ext_ack_n;
            cpu_rdata   <= cpu_rdata_n;
            ext_rdata   <= ext_rdata_n;
            mem_addr    <= mem_addr_n;
            mem_wr_data <= mem_wr_data_n;
            mem_wr_ena  <= mem_wr_ena_n;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 uses MEM_LAT=1 round-robin, instance 1
// uses MEM_LAT=3 with cpu priority. A transaction-level model (grant time plus
// cycle age) predicts every output each cycle; directed literals pin the model.
module tb_mem_port_arbiter;

    localparam int unsigned LAT0 = 1;
    localparam int unsigned LAT1 = 3;

    logic        clk = 1'b0;
    logic        rstb;
    logic        cpu_req   [2];
    logic        cpu_we    [2];
    logic [31:0] cpu_addr  [2];
    logic [31:0] cpu_wdata [2];
    logic        ext_req   [2];
    logic        ext_we    [2];
    logic [31:0] ext_addr  [2];
    logic [31:0] ext_wdata [2];
    logic        cpu_ack   [2];
    logic        ext_ack   [2];
    logic [31:0] cpu_rdata [2];
    logic [31:0] ext_rdata [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wr_data [2];
    logic        mem_wr_ena  [2];
    logic [31:0] mem_rd_data [2];
    logic        busy      [2];
    logic        owner     [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Memory contents as a pure function of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return {~a[15:0], a[15:0]} ^ {16'h0, a[31:16]};
    endfunction

    assign mem_rd_data[0] = memf(mem_addr[0]);
    assign mem_rd_data[1] = memf(mem_addr[1]);

    mem_port_arbiter #(.MEM_LAT(LAT0), .CPU_PRIORITY(0)) dut0 (
        .clk(clk), .rstb(rstb),
        .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]),
        .cpu_wdata(cpu_wdata[0]), .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]),
        .ext_req(ext_req[0]), .ext_we(ext_we[0]), .ext_addr(ext_addr[0]),
        .ext_wdata(ext_wdata[0]), .ext_ack(ext_ack[0]), .ext_rdata(ext_rdata[0]),
        .mem_addr(mem_addr[0]), .mem_wr_data(mem_wr_data[0]),
        .mem_wr_ena(mem_wr_ena[0]), .mem_rd_data(mem_rd_data[0]),
        .busy(busy[0]), .owner(owner[0])
    );

    mem_port_arbiter #(.MEM_LAT(LAT1), .CPU_PRIORITY(1)) dut1 (
        .clk(clk), .rstb(rstb),
        .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]),
        .cpu_wdata(cpu_wdata[1]), .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]),
        .ext_req(ext_req[1]), .ext_we(ext_we[1]), .ext_addr(ext_addr[1]),
        .ext_wdata(ext_wdata[1]), .ext_ack(ext_ack[1]), .ext_rdata(ext_rdata[1]),
        .mem_addr(mem_addr[1]), .mem_wr_data(mem_wr_data[1]),
        .mem_wr_ena(mem_wr_ena[1]), .mem_rd_data(mem_rd_data[1]),
        .busy(busy[1]), .owner(owner[1])
    );

    // ---------------- transaction model ----------------
    bit          m_act   [2];
    int          m_age   [2];
    bit          m_own   [2];
    bit          m_last  [2];
    bit          m_we    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_rd    [2][2];

    function automatic int lat_of(input int i);
        return (i == 0) ? int'(LAT0) : int'(LAT1);
    endfunction

    function automatic bit prio_of(input int i);
        return (i == 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i]   = 1'b0;
            m_age[i]   = 0;
            m_own[i]   = 1'b0;
            m_last[i]  = 1'b1;
            m_we[i]    = 1'b0;
            m_addr[i]  = '0;
            m_wdata[i] = '0;
            m_rd[i][0] = '0;
            m_rd[i][1] = '0;
        end
    endtask

    // Advance one clock edge: an active transaction ages; an idle port samples.
    task automatic model_step();
        bit win;
        for (int i = 0; i < 2; i++) begin
            if (m_act[i]) begin
                m_age[i]++;
                if (m_age[i] == lat_of(i) && !m_we[i])
                    m_rd[i][m_own[i]] = memf(m_addr[i]);
                if (m_age[i] == lat_of(i) + 1)
                    m_act[i] = 1'b0;
            end else if (cpu_req[i] || ext_req[i]) begin
                if (!ext_req[i])      win = 1'b0;
                else if (!cpu_req[i]) win = 1'b1;
                else if (prio_of(i))  win = 1'b0;
                else                  win = !m_last[i];
                m_act[i]   = 1'b1;
                m_age[i]   = 0;
                m_own[i]   = win;
                m_last[i]  = win;
                m_we[i]    = win ? ext_we[i]    : cpu_we[i];
                m_addr[i]  = win ? ext_addr[i]  : cpu_addr[i];
                m_wdata[i] = win ? ext_wdata[i] : cpu_wdata[i];
            end
        end
    endtask

    task automatic chk(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d got=%h want=%h t=%0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic compare();
        bit acc, ackc;
        for (int i = 0; i < 2; i++) begin
            acc  = m_act[i] && (m_age[i] < lat_of(i));
            ackc = m_act[i] && (m_age[i] == lat_of(i));
            chk("busy",      i, 32'(busy[i]),       32'(m_act[i]));
            if (m_act[i]) chk("owner", i, 32'(owner[i]), 32'(m_own[i]));
            chk("mem_addr",  i, mem_addr[i],        acc ? m_addr[i]  : 32'h0);
            chk("mem_wdata", i, mem_wr_data[i],     acc ? m_wdata[i] : 32'h0);
            chk("mem_we",    i, 32'(mem_wr_ena[i]), 32'(m_act[i] && m_age[i] == 0 && m_we[i]));
            chk("cpu_ack",   i, 32'(cpu_ack[i]),    32'(ackc && !m_own[i]));
            chk("ext_ack",   i, 32'(ext_ack[i]),    32'(ackc && m_own[i]));
            chk("cpu_rdata", i, cpu_rdata[i],       m_rd[i][0]);
            chk("ext_rdata", i, ext_rdata[i],       m_rd[i][1]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rstb) model_step();
        #1;
        compare();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int wr, bz, ak, n, cpu_n, ext_n, extra;
        int ord [6];

        rstb = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cpu_req[i] = 0; cpu_we[i] = 0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
            ext_req[i] = 0; ext_we[i] = 0; ext_addr[i] = '0; ext_wdata[i] = '0;
        end
        model_reset();
        repeat (2) tick();
        chk("rst_busy",  0, 32'(busy[0]),    32'h0);
        chk("rst_rdata", 1, cpu_rdata[1],    32'h0);
        rstb = 1'b1;
        tick();

        // single cpu read, latency 1
        cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 32'h40;
        tick();
        chk("t2_addr",      0, mem_addr[0],      32'h40);
        chk("t2_ack_early", 0, 32'(cpu_ack[0]),  32'h0);
        tick();
        chk("t2_ack",       0, 32'(cpu_ack[0]),  32'h1);
        chk("t2_rdata",     0, cpu_rdata[0],     32'hDEADBEEF);
        chk("t2_addr_off",  0, mem_addr[0],      32'h0);
        chk("t2_ext_ack",   0, 32'(ext_ack[0]),  32'h0);
        cpu_req[0] = 0;
        tick();
        chk("t2_idle",      0, 32'(busy[0]),     32'h0);

        // ext write, latency 3
        ext_req[1] = 1; ext_we[1] = 1; ext_addr[1] = 32'h100; ext_wdata[1] = 32'h12345678;
        wr = 0; bz = 0; ak = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            wr += int'(mem_wr_ena[1]);
            bz += int'(busy[1]);
            if (ext_ack[1]) begin
                ak++;
                ext_req[1] = 0;
            end
        end
        ext_we[1] = 0;
        chk("t3_we_cycles",   1, 32'(wr), 32'd1);
        chk("t3_busy_cycles", 1, 32'(bz), 32'd4);
        chk("t3_ack_count",   1, 32'(ak), 32'd1);
        chk("t3_rdata_kept",  1, ext_rdata[1], 32'h0);

        // reset in the middle of a write
        for (int i = 0; i < 2; i++) begin
            cpu_req[i] = 1; cpu_we[i] = 1; cpu_addr[i] = 32'h300; cpu_wdata[i] = 32'hCAFEF00D;
        end
        tick();
        chk("t1_we_on", 0, 32'(mem_wr_ena[0]), 32'h1);
        chk("t1_we_on", 1, 32'(mem_wr_ena[1]), 32'h1);
        #2 rstb = 1'b0;
        #1;
        chk("t1_we_drop", 0, 32'(mem_wr_ena[0]), 32'h0);
        chk("t1_we_drop", 1, 32'(mem_wr_ena[1]), 32'h0);
        chk("t1_busy",    1, 32'(busy[1]),       32'h0);
        model_reset();
        compare();
        for (int i = 0; i < 2; i++) begin
            cpu_req[i] = 0; cpu_we[i] = 0;
        end
        repeat (2) tick();
        rstb = 1'b1;
        ak = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            ak += int'(cpu_ack[0]) + int'(cpu_ack[1]) + int'(ext_ack[0]) + int'(ext_ack[1]);
        end
        chk("t1_no_ack", 0, 32'(ak), 32'h0);

        // round-robin with both ports requesting
        cpu_req[0] = 1; cpu_addr[0] = 32'h80;
        ext_req[0] = 1; ext_addr[0] = 32'hC0;
        n = 0;
        for (int k = 0; k < 40 && n < 6; k++) begin
            tick();
            if (cpu_ack[0]) begin
                chk("t4_cpu_rdata", 0, cpu_rdata[0], 32'hFF7F0080);
                if (n < 6) ord[n] = 0;
                n++;
            end
            if (ext_ack[0]) begin
                chk("t4_ext_rdata", 0, ext_rdata[0], 32'hFF3F00C0);
                if (n < 6) ord[n] = 1;
                n++;
            end
            if (n >= 6) begin
                cpu_req[0] = 0; ext_req[0] = 0;
            end
        end
        cpu_req[0] = 0; ext_req[0] = 0;
        chk("t4_count", 0, 32'(n), 32'd6);
        for (int j = 0; j < 6 && j < n; j++)
            chk("t4_order", 0, 32'(ord[j]), 32'(j % 2));
        repeat (2) tick();

        // cpu priority: ext starves until cpu lets go
        cpu_req[1] = 1; cpu_addr[1] = 32'h80;
        ext_req[1] = 1; ext_addr[1] = 32'hC0;
        cpu_n = 0; ext_n = 0;
        for (int k = 0; k < 40 && cpu_n < 3; k++) begin
            tick();
            if (cpu_ack[1]) cpu_n++;
            if (ext_ack[1]) ext_n++;
            if (cpu_n >= 3) cpu_req[1] = 0;
        end
        cpu_req[1] = 0;
        chk("t5_cpu_wins", 1, 32'(cpu_n), 32'd3);
        chk("t5_ext_none", 1, 32'(ext_n), 32'd0);
        extra = 0;
        for (int k = 0; k < 20 && ext_n == 0; k++) begin
            tick();
            if (ext_ack[1]) ext_n++;
            if (cpu_ack[1]) extra++;
        end
        ext_req[1] = 0;
        chk("t5_ext_served", 1, 32'(ext_n), 32'd1);
        chk("t5_cpu_extra",  1, 32'(extra), 32'd0);
        chk("t5_ext_rdata",  1, ext_rdata[1], 32'hFF3F00C0);
        repeat (2) tick();

        // cpu drops its request mid-access
        cpu_req[1] = 1; cpu_we[1] = 0; cpu_addr[1] = 32'h200;
        tick();
        chk("t6_busy",  1, 32'(busy[1]),  32'h1);
        chk("t6_owner", 1, 32'(owner[1]), 32'h0);
        cpu_req[1] = 0;
        ak = 0;
        for (int k = 0; k < 7; k++) begin
            tick();
            ak += int'(cpu_ack[1]);
        end
        chk("t6_ack_once", 1, 32'(ak), 32'd1);
        chk("t6_idle",     1, 32'(busy[1]), 32'h0);
        chk("t6_rdata",    1, cpu_rdata[1], 32'hFDFF0200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
